mac_operand_feeder: RTL and testbench

Drives the operand side of the 10-bit signed MAC (`a`, `b`, `valid_in`, `reset`) and collects its result (`f`, `valid_out`). Upstream operand pairs are buffered in a small FIFO, issued as a dot-product vector of programmable length, and the final accumulator value is returned on a ready/valid result port. The MAC's accumulator is cleared before every vector, so results never mix.

---
 rtl/mac_feeder_pkg.sv | 17 +
 rtl/mac_operand_fifo.sv | 46 ++++
 rtl/mac_operand_feeder.sv | 143 ++++++++++++++
 tb/tb_mac_operand_feeder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_feeder_pkg.sv
// Shared constants and FSM state type for the MAC operand feeder.
package mac_feeder_pkg;

    localparam int MAC_DW      = 10;
    localparam int MAC_FW      = 20;
    localparam int MAC_LENW    = 8;
    localparam int MAC_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        HOLD
    } state_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous FIFO for operand pairs; push and pop may occur in the same cycle.
module mac_operand_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates the full and empty cases when addresses match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs, issues a programmable-length dot product to the MAC and
// returns the accumulator. Define MAC_FEEDER_SKIP_ZERO_EN to skip zero-operand pairs.
module mac_operand_feeder
    import mac_feeder_pkg::*;
#(
    parameter int DW    = MAC_DW,
    parameter int FW    = MAC_FW,
    parameter int DEPTH = 8,
    parameter int LENW  = MAC_LENW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 start,
    input  logic [LENW-1:0]      vec_len,
    output logic                 busy,
    output logic signed [DW-1:0] mac_a,
    output logic signed [DW-1:0] mac_b,
    output logic                 mac_valid_in,
    output logic                 mac_reset,
    input  logic signed [FW-1:0] mac_f,
    input  logic                 mac_valid_out,
    output logic signed [FW-1:0] res_f,
    output logic                 res_valid,
    input  logic                 res_ready
);

    localparam logic [LENW:0] CNT_ONE = (LENW+1)'(1);

    state_t               state;
    logic [LENW-1:0]      len;
    logic [LENW:0]        consumed;
    logic [LENW:0]        issued;
    logic [LENW:0]        returned;
    logic [2*DW-1:0]      fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 skip;
    logic                 beat;
    logic signed [DW-1:0] head_a;
    logic signed [DW-1:0] head_b;

    mac_operand_fifo #(
        .WIDTH (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid && in_ready),
        .wr_data ({in_a, in_b}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_a    = fifo_rd[2*DW-1:DW];
    assign head_b    = fifo_rd[DW-1:0];
    assign in_ready  = !fifo_full && !reset;
    assign mac_reset = reset || (state == CLEAR);
    assign pop       = (state == ISSUE) && !fifo_empty;
    assign beat      = mac_valid_out && ((state == ISSUE) || (state == DRAIN));

`ifdef MAC_FEEDER_SKIP_ZERO_EN
    assign skip = (head_a == '0) || (head_b == '0);
`else
    assign skip = 1'b0;
`endif

    // NOTE: all state here is registered with non-blocking assignments so every
    // branch sees the values from the start of the cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            len          <= '0;
            consumed     <= '0;
            issued       <= '0;
            returned     <= '0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            res_f        <= '0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            mac_valid_in <= 1'b0;
            if (beat) returned <= returned + CNT_ONE;

            case (state)
                IDLE: begin
                    if (start) begin
                        len      <= vec_len;
                        consumed <= '0;
                        issued   <= '0;
                        returned <= '0;
                        busy     <= 1'b1;
                        if (vec_len != '0) begin
                            state <= CLEAR;
                        end else begin
                            res_f     <= '0;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                CLEAR: state <= ISSUE;
                ISSUE: begin
                    if (pop) begin
                        consumed <= consumed + CNT_ONE;
                        if (!skip) begin
                            mac_a        <= head_a;
                            mac_b        <= head_b;
                            mac_valid_in <= 1'b1;
                            issued       <= issued + CNT_ONE;
                        end
                        if (consumed + CNT_ONE == {1'b0, len}) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Current beat included so the final accumulator is caught as it lands.
                    if (returned + {{LENW{1'b0}}, beat} == issued) begin
                        res_f     <= mac_f;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench: feeder connected back-to-back with a behavioural 2-cycle MAC.
module tb_mac_operand_feeder;
    import mac_feeder_pkg::*;

    localparam int DW   = MAC_DW;
    localparam int FW   = MAC_FW;
    localparam int LENW = MAC_LENW;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] in_a, in_b;
    logic                 in_valid, in_ready;
    logic                 start;
    logic [LENW-1:0]      vec_len;
    logic                 busy;
    logic signed [DW-1:0] mac_a, mac_b;
    logic                 mac_valid_in, mac_reset;
    logic signed [FW-1:0] mac_f;
    logic                 mac_valid_out;
    logic signed [FW-1:0] res_f;
    logic                 res_valid, res_ready;

    logic signed [FW-1:0] prod;
    logic                 v1;

    int tests = 0;
    int fails = 0;
    int r_lat, r_nv, r_span, r_clr, r_rdy;
    logic signed [DW-1:0] pend_a[$];
    logic signed [DW-1:0] pend_b[$];

    always #5 clk = ~clk;

    mac_operand_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .start         (start),
        .vec_len       (vec_len),
        .busy          (busy),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_reset     (mac_reset),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .res_f         (res_f),
        .res_valid     (res_valid),
        .res_ready     (res_ready)
    );

    // Reference MAC: product registered, then accumulated; result two cycles after issue.
    always @(posedge clk) begin
        if (mac_reset) begin
            prod          <= '0;
            v1            <= 1'b0;
            mac_f         <= '0;
            mac_valid_out <= 1'b0;
        end else begin
            prod          <= FW'(mac_a) * FW'(mac_b);
            v1            <= mac_valid_in;
            mac_valid_out <= v1;
            if (v1) mac_f <= mac_f + prod;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Start a vector in cycle 0 and run until res_valid; pending pairs are fed every gap cycles.
    task automatic run_vec(input logic [LENW-1:0] len, input int gap);
        int first, last;
        r_lat = -1; r_nv = 0; r_clr = -1; r_rdy = -1;
        first = -1; last = -1;
        start   = 1'b1;
        vec_len = len;
        for (int c = 0; c < 200; c++) begin
            if (pend_a.size() > 0 && gap > 0 && (c % gap) == 0 && in_ready) begin
                in_a     = pend_a[0];
                in_b     = pend_b[0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (in_valid) begin
                pend_a.delete(0);
                pend_b.delete(0);
            end
            in_valid = 1'b0;
            start    = 1'b0;
            if (mac_reset && r_clr < 0) r_clr = c + 1;
            if (in_ready && r_rdy < 0) r_rdy = c + 1;
            if (mac_valid_in) begin
                r_nv++;
                if (first < 0) first = c + 1;
                last = c + 1;
            end
            if (res_valid) begin
                r_lat = c + 1;
                break;
            end
        end
        r_span = (first < 0) ? 0 : last - first + 1;
    endtask

    task automatic accept(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_res_valid_drop"}, 32'(res_valid), 0);
        check({tag, "_busy_drop"}, 32'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; in_a = '0; in_b = '0; in_valid = 1'b0;
        start = 1'b0; vec_len = '0; res_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mac_reset", 32'(mac_reset), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_mac_valid_in", 32'(mac_valid_in), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_mac_a", 32'(mac_a), 0);
        check("rst_res_f", 32'(res_f), 0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_mac_reset", 32'(mac_reset), 0);

        // Fully buffered vector: (3,4),(-2,5),(7,-1) = 12 - 10 - 7 = -5
        push(10'sd3, 10'sd4);
        push(-10'sd2, 10'sd5);
        push(10'sd7, -10'sd1);
        run_vec(8'd3, 0);
        check("v1_clear_cycle", r_clr, 1);
        check("v1_latency", r_lat, 8);
        check("v1_issues", r_nv, 3);
        check("v1_span", r_span, 3);
        check("v1_res_f", 32'(res_f), -5);
        check("v1_busy", 32'(busy), 1);
        accept("v1");

        // Same vector trickled in every third cycle: issues at 3,5,8; last return 10
        pend_a = '{10'sd3, -10'sd2, 10'sd7};
        pend_b = '{10'sd4, 10'sd5, -10'sd1};
        run_vec(8'd3, 3);
        check("v2_latency", r_lat, 11);
        check("v2_issues", r_nv, 3);
        check("v2_span_bubbles", r_span, 6);
        check("v2_res_f", 32'(res_f), -5);
        accept("v2");

        push(10'sd10, 10'sd10);
        push(10'sd10, 10'sd10);
        run_vec(8'd2, 0);
        check("v3_latency", r_lat, 7);
        check("v3_res_f", 32'(res_f), 200);
        accept("v3");

        // Zero-length vector
        run_vec(8'd0, 0);
        check("v0_latency", r_lat, 1);
        check("v0_issues", r_nv, 0);
        check("v0_clear", r_clr, -1);
        check("v0_res_f", 32'(res_f), 0);
        accept("v0");

        // Fill FIFO with (k,2), k=1..8; a ninth push must be dropped. Sum = 72
        for (int k = 1; k <= 8; k++) push(DW'(k), 10'sd2);
        check("full_in_ready", 32'(in_ready), 0);
        push(10'sd9, 10'sd9);
        check("full_drop_in_ready", 32'(in_ready), 0);
        run_vec(8'd8, 0);
        check("full_rdy_rise", r_rdy, 3);
        check("full_latency", r_lat, 13);
        check("full_issues", r_nv, 8);
        check("full_res_f", 32'(res_f), 72);

        // Back-pressure on the result port while start is held high
        start   = 1'b1;
        vec_len = 8'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_res_f", 32'(res_f), 72);
            check("hold_res_valid", 32'(res_valid), 1);
        end
        check("hold_busy", 32'(busy), 1);
        start = 1'b0;
        accept("hold");
        tick();
        check("hold_after_busy", 32'(busy), 0);
        check("hold_after_empty", 32'(in_ready), 1);

        // Reset in DRAIN with one pair left buffered
        push(10'sd3, 10'sd4);
        push(10'sd5, 10'sd6);
        push(10'sd7, 10'sd8);
        start   = 1'b1;
        vec_len = 8'd2;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_mac_valid_in", 32'(mac_valid_in), 0);
        check("mid_rst_res_valid", 32'(res_valid), 0);
        check("mid_rst_mac_a", 32'(mac_a), 0);
        check("mid_rst_mac_b", 32'(mac_b), 0);
        check("mid_rst_res_f", 32'(res_f), 0);
        check("mid_rst_mac_reset", 32'(mac_reset), 1);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        reset = 1'b0;
        tick();
        check("mid_rst_release_ready", 32'(in_ready), 1);
        push(10'sd511, 10'sd511);
        run_vec(8'd1, 0);
        check("max_latency", r_lat, 6);
        check("max_res_f", 32'(res_f), 261121);
        accept("max");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
